regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port general-purpose register file for the MIPS CPU datapath. It replaces the fixed 32×32 two-read file and adds:

- dedicated link (jal) and overflow write channels, independent of the main write port;
- optional write-to-read bypass;
- a per-register busy scoreboard that the issue logic uses to detect RAW hazards in the pipelined core.

It sits between decode (read addresses, reservations) and writeback (write data, busy clear).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W
- NRD, 2, number of read ports (1..4)
- LINK_REG, 31, register written by the link channel
- OVF_REG, 30, register set to 1 by the overflow channel
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see array only
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  NRD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
- rd_busy  out  NRD  port i address has an outstanding reservation
- wr_en  in  1  main writeback enable
- wr_addr  in  ADDR_W  main write address
- wr_data  in  DATA_W  main write data
- link_en  in  1  write link_data to LINK_REG
- link_data  in  DATA_W  return address
- ovf_set  in  1  write 1 (zero-extended) to OVF_REG
- rsv_en  in  1  reserve destination at issue
- rsv_addr  in  ADDR_W  register to mark busy
- pend_cnt  out  ADDR_W+1  number of busy registers

## Operation
- **Register 0:** reads as 0 and is never busy. Writes and reservations to 0 are discarded.
- **Array write:** all three channels commit on the same clk edge. On an address conflict the priority is wr_en > link_en > ovf_set; exactly one value lands.
- **Independent channels:** link_en and ovf_set do not require wr_en.
- **Read path, BYPASS=1:** rd_data[i] returns the highest-priority same-cycle write targeting rd_addr[i]. Otherwise it returns the array entry.
- **Read path, BYPASS=0:** rd_data[i] always returns the array entry.
- **Busy bit per register, next-edge update:**
  - clear on wr_en for wr_addr;
  - clear on link_en for LINK_REG;
  - clear on ovf_set for OVF_REG;
  - set on rsv_en for rsv_addr.
- **Set/clear conflict:** set and clear on the same address in the same cycle leaves the bit set (new producer issued as the old one retires).
- **Reserving an already-busy register:** the bit stays set. There is no counting per register.
- **rd_busy[i], BYPASS=1:** busy[rd_addr[i]] AND NOT (a clearing write to rd_addr[i] in this cycle).
- **rd_busy[i], BYPASS=0:** raw busy[rd_addr[i]].
- **pend_cnt:** registered popcount of the busy vector, updated on the same edge as the busy bits. Range 0..2^ADDR_W−1.

## Timing
- **Reset:** asynchronous. While rst=1, all array entries are 0, all busy bits 0 and pend_cnt 0. rd_data reflects the cleared array (plus bypass). rd_busy is 0.
- **Reset mid-operation:** pending writes and reservations in the reset cycle are discarded. The first edge after deassertion behaves normally.
- **Write latency:** one edge to the array. Bypass latency is 0 (combinational).
- **Reads:** fully combinational from rd_addr.
- **Busy/pend_cnt latency:** busy bits and pend_cnt change one edge after rsv_en or the clearing write. rd_busy follows combinationally from busy and the current cycle's writes.
- **Read-port independence:** all NRD read ports may alias the same address or a write address in any combination.

## Structure
- **Package regfile_pkg:**
  - default DATA_W/ADDR_W;
  - LINK_REG/OVF_REG constants;
  - a function for write-channel priority select, shared by the array write and the bypass mux.
- **Sub-module rf_scoreboard:**
  - contains the busy vector, set/clear logic and popcount;
  - ports: clk, rst, rsv_en/addr, three clear strobes with addresses, busy vector out, pend_cnt out.
- **Top level:** the array, the generate loop over NRD read ports and the bypass mux stay here.

## Test plan
- **Reset behaviour:** write 0xDEADBEEF to r5, then assert rst mid-cycle. Required: r5 reads 0 immediately and pend_cnt=0; the write in the reset cycle is lost.
- **Write-priority conflict:** wr_en to r31 = 0x1234, link_en = 0x4000 and ovf_set, all same cycle, with rd_addr0=31, rd_addr1=30 and BYPASS=1.
  - Required in the same cycle: rd_data0=0x1234, rd_data1=1.
  - Required after the edge: r31=0x1234, r30=1.
- **Register 0:** wr_en to r0 = 0xFFFFFFFF plus rsv_en r0. Required: r0 reads 0, rd_busy=0, pend_cnt unchanged.
- **Scoreboard:**
  - rsv r8, r9 → pend_cnt=2 after the edge.
  - wr_en r8 while rsv_en r8 in the same cycle → r8 stays busy, pend_cnt=2.
  - wr_en r9 → pend_cnt=1.
- **Bypass off:** BYPASS=0, wr_en r3 = 7 while reading r3. Required: old value this cycle, 7 next cycle; rd_busy raw.
- **NRD=4 aliasing:** all four ports read r12 while it is being written. Required: all four ports identical every cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults, fixed register numbers and the write-channel priority
// select used by both the array write and the bypass mux.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned ADDR_W_DEF   = 5;
  localparam int unsigned LINK_REG_DEF = 31;
  localparam int unsigned OVF_REG_DEF  = 30;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_WR   = 2'd1,
    SEL_LINK = 2'd2,
    SEL_OVF  = 2'd3
  } wsel_e;

  // Main writeback beats link, link beats overflow.
  function automatic wsel_e wr_pick(input logic hit_wr, input logic hit_link,
                                    input logic hit_ovf);
    if (hit_wr)   return SEL_WR;
    if (hit_link) return SEL_LINK;
    if (hit_ovf)  return SEL_OVF;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for RAW hazard detection, plus a registered
// popcount of the busy vector.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  input  logic                   clr_wr_en,
  input  logic [ADDR_W-1:0]      clr_wr_addr,
  input  logic                   clr_link_en,
  input  logic [ADDR_W-1:0]      clr_link_addr,
  input  logic                   clr_ovf_en,
  input  logic [ADDR_W-1:0]      clr_ovf_addr,
  output logic [2**ADDR_W-1:0]   busy,
  output logic [ADDR_W:0]        pend_cnt
);

  logic [2**ADDR_W-1:0] busy_nxt;
  logic [ADDR_W:0]      cnt_nxt;

  // Set is applied after the clears so a new producer issued as the old
  // one retires keeps the register busy.
  always_comb begin
    busy_nxt = busy;
    if (clr_wr_en)   busy_nxt[clr_wr_addr]   = 1'b0;
    if (clr_link_en) busy_nxt[clr_link_addr] = 1'b0;
    if (clr_ovf_en)  busy_nxt[clr_ovf_addr]  = 1'b0;
    if (rsv_en)      busy_nxt[rsv_addr]      = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int unsigned j = 0; j < 2**ADDR_W; j++) begin
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[j]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with link/overflow write channels,
// optional write-to-read bypass and a busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NRD      = 2,
  parameter int unsigned LINK_REG = LINK_REG_DEF,
  parameter int unsigned OVF_REG  = OVF_REG_DEF,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  link_en,
  input  logic [DATA_W-1:0]     link_data,
  input  logic                  ovf_set,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic [ADDR_W:0]       pend_cnt
);

  localparam int unsigned       DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A  = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] OVF_A   = ADDR_W'(OVF_REG);
  localparam logic [DATA_W-1:0] OVF_VAL = DATA_W'(1);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned j = 0; j < DEPTH; j++) regs[j] <= '0;
    end else begin
      for (int unsigned j = 1; j < DEPTH; j++) begin
        case (wr_pick(wr_en && (wr_addr == ADDR_W'(j)),
                      link_en && (LINK_A == ADDR_W'(j)),
                      ovf_set && (OVF_A == ADDR_W'(j))))
          SEL_WR:   regs[j] <= wr_data;
          SEL_LINK: regs[j] <= link_data;
          SEL_OVF:  regs[j] <= OVF_VAL;
          default:  ;
        endcase
      end
    end
  end

  rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk           (clk),
    .rst           (rst),
    .rsv_en        (rsv_en),
    .rsv_addr      (rsv_addr),
    .clr_wr_en     (wr_en),
    .clr_wr_addr   (wr_addr),
    .clr_link_en   (link_en),
    .clr_link_addr (LINK_A),
    .clr_ovf_en    (ovf_set),
    .clr_ovf_addr  (OVF_A),
    .busy          (busy),
    .pend_cnt      (pend_cnt)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              hit_clr;

    assign a = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      d       = (a == '0) ? '0 : regs[a];
      hit_clr = 1'b0;
      if ((BYPASS != 0) && (a != '0)) begin
        case (wr_pick(wr_en && (wr_addr == a),
                      link_en && (LINK_A == a),
                      ovf_set && (OVF_A == a)))
          SEL_WR:   d = wr_data;
          SEL_LINK: d = link_data;
          SEL_OVF:  d = OVF_VAL;
          default:  ;
        endcase
        hit_clr = (wr_en && (wr_addr == a)) || (link_en && (LINK_A == a)) ||
                  (ovf_set && (OVF_A == a));
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = d;
    assign rd_busy[i] = busy[a] & ~hit_clr;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a 4-port bypassing instance and a 2-port
// non-bypassing instance share the write/reservation inputs.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, link_en, ovf_set, rsv_en;
  logic [4:0]  wr_addr, rsv_addr;
  logic [31:0] wr_data, link_data;
  logic [19:0] rd_addr_a;
  logic [127:0] rd_data_a;
  logic [3:0]  rd_busy_a;
  logic [5:0]  pend_a;
  logic [9:0]  rd_addr_b;
  logic [63:0] rd_data_b;
  logic [1:0]  rd_busy_b;
  logic [5:0]  pend_b;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(4), .LINK_REG(31), .OVF_REG(30), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .link_en(link_en),
    .link_data(link_data), .ovf_set(ovf_set), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .pend_cnt(pend_a));

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .LINK_REG(31), .OVF_REG(30), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .link_en(link_en),
    .link_data(link_data), .ovf_set(ovf_set), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .pend_cnt(pend_b));

  // Reference model: plain register array plus a set of busy flags.
  logic [31:0] m_mem [32];
  bit   [31:0] m_busy;

  function automatic logic [31:0] m_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp) begin
      if (wr_en && wr_addr == a) return wr_data;
      if (link_en && a == 5'd31) return link_data;
      if (ovf_set && a == 5'd30) return 32'd1;
    end
    return m_mem[a];
  endfunction

  function automatic logic m_rbusy(input logic [4:0] a, input bit byp);
    if (!m_busy[a]) return 1'b0;
    if (byp && ((wr_en && wr_addr == a) || (link_en && a == 5'd31) ||
                (ovf_set && a == 5'd30))) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 32; j++) m_mem[j] = 32'd0;
    m_busy = '0;
  endtask

  task automatic commit();
    if (rst) begin
      model_reset();
    end else begin
      if (ovf_set) m_mem[30] = 32'd1;
      if (link_en) m_mem[31] = link_data;
      if (wr_en)   m_mem[wr_addr] = wr_data;
      m_mem[0] = 32'd0;
      if (wr_en)   m_busy[wr_addr] = 1'b0;
      if (link_en) m_busy[31] = 1'b0;
      if (ovf_set) m_busy[30] = 1'b0;
      if (rsv_en)  m_busy[rsv_addr] = 1'b1;
      m_busy[0] = 1'b0;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check();
    logic [4:0] a;
    for (int i = 0; i < 4; i++) begin
      a = rd_addr_a[i*5 +: 5];
      cmp($sformatf("rd_data_a[%0d]", i), rd_data_a[i*32 +: 32], m_read(a, 1'b1));
      cmp($sformatf("rd_busy_a[%0d]", i), {31'd0, rd_busy_a[i]}, {31'd0, m_rbusy(a, 1'b1)});
    end
    for (int i = 0; i < 2; i++) begin
      a = rd_addr_b[i*5 +: 5];
      cmp($sformatf("rd_data_b[%0d]", i), rd_data_b[i*32 +: 32], m_read(a, 1'b0));
      cmp($sformatf("rd_busy_b[%0d]", i), {31'd0, rd_busy_b[i]}, {31'd0, m_rbusy(a, 1'b0)});
    end
    cmp("pend_a", 32'(pend_a), 32'($countones(m_busy)));
    cmp("pend_b", 32'(pend_b), 32'($countones(m_busy)));
  endtask

  // Called at posedge+1 with inputs set: check late in the cycle, then edge.
  task automatic cycle();
    #3;
    check();
    commit();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic le, input logic [31:0] ld, input logic os,
                       input logic re, input logic [4:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; link_en = le; link_data = ld;
    ovf_set = os; rsv_en = re; rsv_addr = ra;
  endtask

  task automatic set_rd(input logic [4:0] r0, input logic [4:0] r1);
    rd_addr_a = {r1, r0, r1, r0};
    rd_addr_b = {r1, r0};
  endtask

  typedef struct {
    logic we; logic [4:0] wa; logic [31:0] wd;
    logic le; logic [31:0] ld; logic os;
    logic re; logic [4:0] ra;
    logic [4:0] r0, r1;
    logic [31:0] e0, e1;
    logic eb0, eb1;
    logic [5:0] ep;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic le, input logic [31:0] ld, input logic os,
                              input logic re, input logic [4:0] ra,
                              input logic [4:0] r0, input logic [4:0] r1,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic eb0, input logic eb1, input logic [5:0] ep);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.le = le; v.ld = ld; v.os = os;
    v.re = re; v.ra = ra; v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1;
    v.eb0 = eb0; v.eb1 = eb1; v.ep = ep;
    return v;
  endfunction

  function automatic logic [4:0] rand_addr();
    logic [4:0] pick [3];
    pick[0] = 5'd0; pick[1] = 5'd30; pick[2] = 5'd31;
    if ($urandom_range(0, 3) == 0) return pick[$urandom_range(0, 2)];
    return 5'($urandom_range(0, 15));
  endfunction

  vec_t tbl [10];

  initial begin
    tbl[0] = mk(1, 31, 32'h1234, 1, 32'h4000, 1, 0, 0, 31, 30, 32'h1234, 32'h1, 0, 0, 0);
    tbl[1] = mk(0, 0, 0, 0, 0, 0, 0, 0,                31, 30, 32'h1234, 32'h1, 0, 0, 0);
    tbl[2] = mk(0, 0, 0, 1, 32'h4000, 0, 0, 0,         31, 30, 32'h4000, 32'h1, 0, 0, 0);
    tbl[3] = mk(0, 0, 0, 0, 0, 0, 0, 0,                31, 30, 32'h4000, 32'h1, 0, 0, 0);
    tbl[4] = mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0,    0, 0, 32'h0, 32'h0, 0, 0, 0);
    tbl[5] = mk(0, 0, 0, 0, 0, 0, 1, 8,                8, 9, 32'h0, 32'h0, 0, 0, 0);
    tbl[6] = mk(0, 0, 0, 0, 0, 0, 1, 9,                8, 9, 32'h0, 32'h0, 1, 0, 1);
    tbl[7] = mk(1, 8, 32'hAA, 0, 0, 0, 1, 8,           8, 9, 32'hAA, 32'h0, 0, 1, 2);
    tbl[8] = mk(1, 9, 32'h55, 0, 0, 0, 0, 0,           8, 9, 32'hAA, 32'h55, 1, 0, 2);
    tbl[9] = mk(0, 0, 0, 0, 0, 0, 0, 0,                8, 9, 32'hAA, 32'h55, 1, 0, 1);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    set_rd(5'd31, 5'd30);
    model_reset();
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;

    // Directed table: priority conflict, link channel, r0, scoreboard.
    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].le, tbl[k].ld, tbl[k].os,
            tbl[k].re, tbl[k].ra);
      set_rd(tbl[k].r0, tbl[k].r1);
      #2;
      cmp($sformatf("tbl%0d.d0", k), rd_data_a[31:0],  tbl[k].e0);
      cmp($sformatf("tbl%0d.d1", k), rd_data_a[63:32], tbl[k].e1);
      cmp($sformatf("tbl%0d.b0", k), {31'd0, rd_busy_a[0]}, {31'd0, tbl[k].eb0});
      cmp($sformatf("tbl%0d.b1", k), {31'd0, rd_busy_a[1]}, {31'd0, tbl[k].eb1});
      cmp($sformatf("tbl%0d.pend", k), 32'(pend_a), 32'(tbl[k].ep));
      #1;
      check();
      commit();
      @(posedge clk); #1;
    end

    // Bypass off: old value in the write cycle, raw busy.
    drive(1, 3, 32'd2, 0, 0, 0, 1, 3); set_rd(5'd3, 5'd3);
    cycle();
    drive(1, 3, 32'd7, 0, 0, 0, 0, 0);
    #2;
    cmp("nobyp.old",  rd_data_b[31:0], 32'd2);
    cmp("nobyp.raw",  {31'd0, rd_busy_b[0]}, 32'd1);
    cmp("byp.new",    rd_data_a[31:0], 32'd7);
    cmp("byp.busy",   {31'd0, rd_busy_a[0]}, 32'd0);
    #1; check(); commit(); @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    cmp("nobyp.next", rd_data_b[31:0], 32'd7);
    cmp("nobyp.clr",  {31'd0, rd_busy_b[0]}, 32'd0);
    #1; check(); commit(); @(posedge clk); #1;

    // Reset mid-cycle with a write and a reservation pending.
    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 1, 6); set_rd(5'd5, 5'd6);
    cycle();
    drive(1, 5, 32'hCAFE_0000, 0, 0, 0, 1, 5);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    cmp("rst.r5",   rd_data_b[31:0], 32'd0);
    cmp("rst.pend", 32'(pend_a), 32'd0);
    cmp("rst.busy", {28'd0, rd_busy_a}, 32'd0);
    check(); commit(); @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cycle();
    cmp("rst.lost", rd_data_a[31:0], 32'd0);
    cycle();

    // All four ports alias r12 while it is written.
    for (int k = 0; k < 6; k++) begin
      drive(k % 2 == 0, 12, $urandom, 0, 0, 0, k == 1, 12);
      rd_addr_a = {4{5'd12}};
      rd_addr_b = {2{5'd12}};
      cycle();
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 1) == 1, rand_addr(), $urandom,
            $urandom_range(0, 4) == 0, $urandom, $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) < 2, rand_addr());
      for (int i = 0; i < 4; i++)
        rd_addr_a[i*5 +: 5] = ($urandom_range(0, 3) == 0) ? wr_addr : rand_addr();
      for (int i = 0; i < 2; i++)
        rd_addr_b[i*5 +: 5] = ($urandom_range(0, 3) == 0) ? wr_addr : rand_addr();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
